// File: rtl/mul_pkg.sv
// Shared definitions for the sequential Booth multiplier.
package mul_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned STEPS = 32;
    localparam int unsigned CNT_W = 5;

    // Sequencer states; encodings are fixed so other blocks can decode them.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Booth select codes taken from {Qr[0], q_1}.
    localparam logic [1:0] BOOTH_NOP0 = 2'b00;
    localparam logic [1:0] BOOTH_ADD  = 2'b01;
    localparam logic [1:0] BOOTH_SUB  = 2'b10;
    localparam logic [1:0] BOOTH_NOP1 = 2'b11;

endpackage

// File: rtl/adder_32_bit.sv
// 32-bit ripple-style adder with carry in/out, shared by the multiplier.
module adder_32_bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [32:0] w_full;

    // Plain 33-bit add; carry out is the top bit.
    always_comb begin
        w_full = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        sum    = w_full[31:0];
        cout   = w_full[32];
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Multi-cycle signed 32x32 radix-2 Booth multiplier sharing one 32-bit adder.
module booth_mul_seq
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = mul_pkg::WIDTH,
    parameter int unsigned STEPS = mul_pkg::STEPS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_qr;
    logic               r_q1;
    logic [WIDTH-1:0]   r_m;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic [WIDTH-1:0]   w_b;
    logic               w_cin;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic               w_sign;
    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   w_a_next;
    logic [WIDTH-1:0]   w_qr_next;

    assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last   = (r_state == S_RUN) && (r_count == CNT_W'(STEPS - 1));

    // Booth operand select: add M, subtract M (invert + carry in) or pass A.
    always_comb begin
        w_b   = '0;
        w_cin = 1'b0;
        case ({r_qr[0], r_q1})
            BOOTH_ADD: begin
                w_b   = r_m;
                w_cin = 1'b0;
            end
            BOOTH_SUB: begin
                w_b   = ~r_m;
                w_cin = 1'b1;
            end
            default: begin
                w_b   = '0;
                w_cin = 1'b0;
            end
        endcase
    end

    adder_32_bit u_adder (
        .a    (r_a),
        .b    (w_b),
        .cin  (w_cin),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // True 33-bit sign of the sum, so M = 0x80000000 shifts in correctly.
    always_comb begin
        w_sign    = r_a[WIDTH-1] ^ w_b[WIDTH-1] ^ w_cout;
        w_a_next  = {w_sign, w_sum[WIDTH-1:1]};
        w_qr_next = {w_sum[0], r_qr[WIDTH-1:1]};
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  w_state_next = start ? S_RUN : S_IDLE;
            S_RUN:   w_state_next = w_last ? S_DONE : S_RUN;
            S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Working registers: load on accept, one Booth step per RUN edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_qr    <= '0;
            r_q1    <= 1'b0;
            r_m     <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_a     <= '0;
            r_qr    <= multiplier;
            r_q1    <= 1'b0;
            r_m     <= multiplicand;
            r_count <= '0;
        end else if (r_state == S_RUN) begin
            r_a     <= w_a_next;
            r_qr    <= w_qr_next;
            r_q1    <= r_qr[0];
            r_count <= r_count + 1'b1;
        end
    end

    // Result registers update only on the final step of a completed run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_last) begin
            r_hi <= w_a_next;
            r_lo <= w_qr_next;
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
